burst_mem_responder: RTL and testbench



---
 rtl/burst_mem_pkg.sv | 17 +
 rtl/burst_mem_if.sv | 22 ++
 rtl/burst_mem_array.sv | 28 ++
 rtl/burst_mem_responder.sv | 133 +++++++++++++
 tb/tb_burst_mem_responder.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/burst_mem_pkg.sv
// Shared types and constants for the 4-beat burst memory responder.
// Optional bubble between beats 1 and 2: define BURST_MEM_STALL_EN.
package burst_mem_pkg;
  localparam int BEATS       = 4;
  localparam int BEAT_W      = 64;
  localparam int LINE_W      = 256;
  localparam int OFFSET_BITS = 5;

  typedef logic [1:0] beat_idx_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_BEAT,
    S_RELEASE
  } state_t;
endpackage

// File: rtl/burst_mem_if.sv
// Initiator <-> memory burst bus.
// master = initiator side, slave = memory side.
interface burst_mem_if;
  import burst_mem_pkg::*;

  logic [31:0]       address_i;
  logic              read_i;
  logic              write_i;
  logic [BEAT_W-1:0] burst_i;
  logic [BEAT_W-1:0] burst_o;
  logic              resp_o;

  modport master (
    output address_i, read_i, write_i, burst_i,
    input  burst_o, resp_o
  );

  modport slave (
    input  address_i, read_i, write_i, burst_i,
    output burst_o, resp_o
  );
endinterface

// File: rtl/burst_mem_array.sv
// Line store: synchronous 256-bit read port, per-beat 64-bit write.
// Not reset, so it maps onto FPGA block RAM.
module burst_mem_array
  import burst_mem_pkg::*;
#(
  parameter int DEPTH_LINES = 16,
  parameter int IDX_W       = 4
) (
  input  logic              clk,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic              i_we,
  input  beat_idx_t         i_wbeat,
  input  logic [BEAT_W-1:0] i_wdata,
  output logic [LINE_W-1:0] o_rdata
);

  logic [LINE_W-1:0] r_mem [DEPTH_LINES];
  logic [LINE_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we)
      r_mem[i_idx][BEAT_W*i_wbeat +: BEAT_W] <= i_wdata;
    r_rdata <= r_mem[i_idx];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/burst_mem_responder.sv
// Burst memory responder: FSM, latency/beat counters, output regs.
// Define BURST_MEM_STALL_EN for a bubble between beats 1 and 2.
module burst_mem_responder
  import burst_mem_pkg::*;
#(
  parameter int LATENCY     = 3,
  parameter int DEPTH_LINES = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  burst_mem_if.slave bus
);

  localparam int IDX_W =
    (DEPTH_LINES > 1) ? $clog2(DEPTH_LINES) : 1;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_lat;
  beat_idx_t         r_beat;
  beat_idx_t         w_beat_nxt;
  logic              r_bubble;
  logic              w_bub_nxt;
  logic              r_is_rd;
  logic [IDX_W-1:0]  r_idx;
  logic              r_resp;
  logic              w_resp_nxt;
  logic [BEAT_W-1:0] r_burst;
  logic [BEAT_W-1:0] w_burst_nxt;
  logic [LINE_W-1:0] w_rdata;
  logic              w_req;
  logic              w_cap;
  logic              w_last;
  logic              w_bub_go;
  logic              w_we;
  logic              w_unused;

  assign w_unused = ^bus.address_i;
  assign w_req    = bus.read_i | bus.write_i;
  assign w_cap    = (r_state == S_BEAT) && !r_bubble;
  assign w_last   = w_cap && (r_beat == 2'd3);
  assign w_we     = w_cap && !r_is_rd && reset_n;

`ifdef BURST_MEM_STALL_EN
  assign w_bub_go = w_cap && (r_beat == 2'd1);
`else
  assign w_bub_go = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_lat    <= '0;
      r_beat   <= '0;
      r_bubble <= 1'b0;
      r_is_rd  <= 1'b0;
      r_idx    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_beat   <= w_beat_nxt;
      r_bubble <= w_bub_nxt;
      if (r_state == S_IDLE && w_req) begin
        r_is_rd <= bus.read_i;
        r_idx   <= bus.address_i[OFFSET_BITS +: IDX_W];
        r_lat   <= LATENCY[3:0];
      end else if (r_state == S_WAIT && r_lat != 4'd0) begin
        r_lat   <= r_lat - 4'd1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    w_bub_nxt   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_beat_nxt = '0;
        if (w_req) w_state_nxt = S_WAIT;
      end
      S_WAIT:
        if (r_lat == 4'd0) w_state_nxt = S_BEAT;
      S_BEAT: begin
        if (!r_bubble) w_beat_nxt = r_beat + 2'd1;
        w_bub_nxt = w_bub_go;
        if (w_last) w_state_nxt = S_RELEASE;
      end
      S_RELEASE:
        if (!w_req) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are computed from next-state and then registered.
  always_comb begin
    w_resp_nxt  = (w_state_nxt == S_BEAT) && !w_bub_nxt;
    w_burst_nxt = '0;
    unique case (1'b1)
      w_resp_nxt && r_is_rd:
        w_burst_nxt = w_rdata[BEAT_W*w_beat_nxt +: BEAT_W];
      w_bub_nxt:
        w_burst_nxt = r_burst;
      default:
        w_burst_nxt = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_resp  <= 1'b0;
      r_burst <= '0;
    end else begin
      r_resp  <= w_resp_nxt;
      r_burst <= w_burst_nxt;
    end
  end

  assign bus.resp_o  = r_resp;
  assign bus.burst_o = r_burst;

  burst_mem_array #(
    .DEPTH_LINES (DEPTH_LINES),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk     (clk),
    .i_idx   (r_idx),
    .i_we    (w_we),
    .i_wbeat (r_beat),
    .i_wdata (bus.burst_i),
    .o_rdata (w_rdata)
  );

endmodule

// File: tb/tb_burst_mem_responder.sv
// Directed bench for burst_mem_responder (LATENCY=3, 16 lines).
// Honours BURST_MEM_STALL_EN for the expected beat pattern.
module tb_burst_mem_responder;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_errors;

  burst_mem_if bus ();

  burst_mem_responder #(
    .LATENCY     (3),
    .DEPTH_LINES (16)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef BURST_MEM_STALL_EN
  localparam logic [15:0] M_FULL = 16'h01B0;
  localparam logic [15:0] M_RST  = 16'h00B0;
`else
  localparam logic [15:0] M_FULL = 16'h00F0;
  localparam logic [15:0] M_RST  = 16'h0070;
`endif

  localparam logic [63:0] B1 = 64'h1111111111111111;
  localparam logic [63:0] B2 = 64'h2222222222222222;
  localparam logic [63:0] B3 = 64'h3333333333333333;
  localparam logic [63:0] B4 = 64'h4444444444444444;
  localparam logic [63:0] B5 = 64'h5555555555555555;
  localparam logic [63:0] B6 = 64'h6666666666666666;
  localparam logic [63:0] B7 = 64'h7777777777777777;
  localparam logic [63:0] B8 = 64'h8888888888888888;
  localparam logic [63:0] BA = 64'hAAAAAAAAAAAAAAAA;
  localparam logic [63:0] BB = 64'hBBBBBBBBBBBBBBBB;
  localparam logic [63:0] BC = 64'hCCCCCCCCCCCCCCCC;
  localparam logic [63:0] BD = 64'hDDDDDDDDDDDDDDDD;
  localparam logic [63:0] BE = 64'hEEEEEEEEEEEEEEEE;

  task automatic check(
    input string        tag,
    input logic [255:0] got,
    input logic [255:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Runs one request for 15 cycles after acceptance; drops it at
  // cycle 12. rst_at >= 0 pulls reset low during that beat.
  task automatic run_burst(
    input  logic [31:0]  a,
    input  logic         rd,
    input  logic         wr,
    input  logic [255:0] wd,
    input  int           rst_at,
    output logic [255:0] rdat,
    output logic [15:0]  mask
  );
    int k;
    k    = 0;
    mask = '0;
    rdat = '0;
    @(negedge clk);
    bus.address_i = a;
    bus.read_i    = rd;
    bus.write_i   = wr;
    @(posedge clk);
    for (int c = 1; c < 16; c++) begin
      @(posedge clk);
      #1;
      if (bus.resp_o) begin
        mask[c] = 1'b1;
        if (k < 4) begin
          rdat[64*k +: 64] = bus.burst_o;
          bus.burst_i      = wd[64*k +: 64];
        end
        if (k == rst_at) begin
          reset_n     = 1'b0;
          bus.read_i  = 1'b0;
          bus.write_i = 1'b0;
        end
        k++;
      end
      if (c == 12) begin
        bus.read_i  = 1'b0;
        bus.write_i = 1'b0;
      end
    end
    bus.burst_i = '0;
  endtask

  logic [255:0] rdat;
  logic [15:0]  mask;

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    reset_n       = 1'b0;
    bus.address_i = '0;
    bus.read_i    = 1'b0;
    bus.write_i   = 1'b0;
    bus.burst_i   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_resp",  {255'b0, bus.resp_o}, 256'd0);
    check("reset_burst", {192'b0, bus.burst_o}, 256'd0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    run_burst(32'h40, 1'b0, 1'b1, {B4, B3, B2, B1}, -1, rdat, mask);
    check("wr_mask",  {240'b0, mask}, {240'b0, M_FULL});
    check("wr_burst", rdat, 256'd0);

    run_burst(32'h40, 1'b1, 1'b0, '0, -1, rdat, mask);
    check("rd_mask", {240'b0, mask}, {240'b0, M_FULL});
    check("rd_b0", {192'b0, rdat[63:0]},    {192'b0, B1});
    check("rd_b1", {192'b0, rdat[127:64]},  {192'b0, B2});
    check("rd_b2", {192'b0, rdat[191:128]}, {192'b0, B3});
    check("rd_b3", {192'b0, rdat[255:192]}, {192'b0, B4});

    run_burst(32'h80, 1'b0, 1'b1, {B8, B7, B6, B5}, -1, rdat, mask);
    check("wr4_mask", {240'b0, mask}, {240'b0, M_FULL});

    run_burst(32'h80, 1'b1, 1'b1, {4{BE}}, -1, rdat, mask);
    check("both_mask", {240'b0, mask}, {240'b0, M_FULL});
    check("both_data", rdat, {B8, B7, B6, B5});

    run_burst(32'h80, 1'b1, 1'b0, '0, -1, rdat, mask);
    check("line4_kept", rdat, {B8, B7, B6, B5});

    run_burst(32'h40, 1'b0, 1'b1, {BD, BC, BB, BA}, 2, rdat, mask);
    check("rst_mask",  {240'b0, mask}, {240'b0, M_RST});
    check("rst_resp",  {255'b0, bus.resp_o}, 256'd0);
    check("rst_burst", {192'b0, bus.burst_o}, 256'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    run_burst(32'h40, 1'b1, 1'b0, '0, -1, rdat, mask);
    check("post_rst_mask", {240'b0, mask}, {240'b0, M_FULL});
    check("post_rst_data", rdat, {B4, B3, BB, BA});

    run_burst(32'h45F, 1'b1, 1'b0, '0, -1, rdat, mask);
    check("alias_data", rdat, {B4, B3, BB, BA});

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
